// File: rtl/frame_bus_pkg.sv
// -----------------------------------------------------------------------------
// frame_bus_pkg
// Shared definitions for the scl/sda frame bus master.
//   FRAME_BITS : width of one code carried by a frame
//   BIT_IDX_W  : width of the down-counter that walks the code MSB-first
//   phase_t    : one value per bus phase; every non-IDLE phase lasts DIV
//                system clocks
// -----------------------------------------------------------------------------
package frame_bus_pkg;

    localparam int FRAME_BITS = 4;
    localparam int BIT_IDX_W  = 2;

    // BIT_LO/BIT_HI are reused for all four data bits; the bit index
    // counter selects which bit of the latched code is on the wire.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        BIT_LO   = 4'd2,
        BIT_HI   = 4'd3,
        DUMMY_LO = 4'd4,
        DUMMY_HI = 4'd5,
        STOP_LO  = 4'd6,
        STOP_HI  = 4'd7,
        GAP      = 4'd8
    } phase_t;

endpackage

// File: rtl/serial_frame_master_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin selector. The search starts one above the last winner and
// wraps, so every requester is served within NREQ grants.
//   clk     : system clock
//   rst     : synchronous active-high reset; pointer returns to NREQ-1 so
//             requester 0 has first priority
//   req     : request vector, already qualified by the caller
//   advance : move the pointer to the current winner
//   grant   : one-hot winner (combinational), all-zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = ptr;
        sel   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sel = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                win        = sel;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(NREQ - 1);
        end else if (advance && found) begin
            ptr <= win;
        end
    end

endmodule

// File: rtl/serial_frame_master.sv
// -----------------------------------------------------------------------------
// serial_frame_master
// Shares a two-wire scl/sda frame bus among NREQ requesters and sends one
// 4-bit code per frame: start, 4 data bits MSB-first, one dummy clock, stop.
// Each bus phase lasts DIV system clocks; a frame is 14 phases.
//
// Request/accept: req is a level. It is only looked at in IDLE; in the cycle
// a requester wins, grant pulses for one cycle and that requester's code is
// latched. After that, req and data_in are ignored until the frame ends.
//
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   req     : [NREQ] level requests
//   data_in : [NREQ*4] requester i's code at data_in[4*i+3:4*i]
//   grant   : [NREQ] one-hot accept pulse
//   busy    : high from the cycle after grant through the done cycle
//   done    : one-cycle pulse in the last cycle of the frame
//   scl     : bus clock, registered
//   sda     : bus data, registered
// -----------------------------------------------------------------------------
module serial_frame_master #(
    parameter int NREQ = 4,
    parameter int DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*4-1:0] data_in,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              done,
    output logic              scl,
    output logic              sda
);

    import frame_bus_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    phase_t                 state, state_n;
    logic [CW-1:0]          phase, phase_n;
    logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [FRAME_BITS-1:0]  code, code_n;
    logic [NREQ-1:0]        arb_req;
    logic [NREQ-1:0]        arb_grant;
    logic                   phase_end;
    logic                   scl_n, sda_n;

    // Requests only compete while the bus is idle and out of reset.
    assign arb_req = (state == IDLE && !rst) ? req : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (|arb_grant),
        .grant   (arb_grant)
    );

    assign grant     = arb_grant;
    assign phase_end = (phase == CW'(DIV - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == GAP) && phase_end;

    // Next-state logic
    always_comb begin
        state_n   = state;
        phase_n   = phase_end ? '0 : phase + CW'(1);
        bit_idx_n = bit_idx;
        code_n    = code;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (|arb_grant) begin
                    state_n = START;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_grant[i]) begin
                            code_n = data_in[FRAME_BITS*i +: FRAME_BITS];
                        end
                    end
                end
            end
            START: begin
                if (phase_end) begin
                    state_n   = BIT_LO;
                    bit_idx_n = '1;
                end
            end
            BIT_LO:   if (phase_end) state_n = BIT_HI;
            BIT_HI: begin
                if (phase_end) begin
                    if (bit_idx == '0) begin
                        state_n = DUMMY_LO;
                    end else begin
                        state_n   = BIT_LO;
                        bit_idx_n = bit_idx - BIT_IDX_W'(1);
                    end
                end
            end
            DUMMY_LO: if (phase_end) state_n = DUMMY_HI;
            DUMMY_HI: if (phase_end) state_n = STOP_LO;
            STOP_LO:  if (phase_end) state_n = STOP_HI;
            STOP_HI:  if (phase_end) state_n = GAP;
            GAP:      if (phase_end) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Bus levels for the cycle after the clock edge, so scl/sda come
    // straight from flops.
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state_n)
            IDLE:     begin scl_n = 1'b1; sda_n = 1'b1;              end
            START:    begin scl_n = 1'b1; sda_n = 1'b0;              end
            BIT_LO:   begin scl_n = 1'b0; sda_n = code_n[bit_idx_n]; end
            BIT_HI:   begin scl_n = 1'b1; sda_n = code_n[bit_idx_n]; end
            DUMMY_LO: begin scl_n = 1'b0; sda_n = 1'b0;              end
            DUMMY_HI: begin scl_n = 1'b1; sda_n = 1'b0;              end
            STOP_LO:  begin scl_n = 1'b0; sda_n = 1'b0;              end
            STOP_HI:  begin scl_n = 1'b1; sda_n = 1'b0;              end
            GAP:      begin scl_n = 1'b1; sda_n = 1'b1;              end
            default:  begin scl_n = 1'b1; sda_n = 1'b1;              end
        endcase
        // In the first cycle of a low phase scl is falling, so sda keeps its
        // old level and moves one cycle later; scl and sda never switch in
        // the same cycle. DIV >= 2 guarantees the low phase has a 2nd cycle.
        if (!scl_n && phase_n == '0) begin
            sda_n = sda;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            bit_idx <= '0;
            code    <= '0;
            scl     <= 1'b1;
            sda     <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_idx_n;
            code    <= code_n;
            scl     <= scl_n;
            sda     <= sda_n;
        end
    end

endmodule

// File: doc/serial_frame_master.md
Name: serial_frame_master

Overview:
- Master-side controller for the two-wire scl/sda frame bus that drives the 4-bit code receiver.
- Shares the bus among NREQ local requesters using round-robin arbitration.
- Serialises each granted 4-bit code as: start condition, 4 data bits MSB-first, one dummy clock, stop condition.
- All bus timing is derived from the system clock by a half-period divider.

Parameters:
- NREQ, 4: number of requesters; must be >= 2.
- DIV, 4: system clocks per scl half-period (one "phase"); must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request; one bit per requester.
- data_in  in  NREQ*4  requester i's code is data_in[4*i+3:4*i].
- grant  out  NREQ  one-hot, one-cycle pulse in the cycle a request is accepted.
- busy  out  1  high from the cycle after grant through the done cycle.
- done  out  1  one-cycle pulse in the last cycle of the frame.
- scl  out  1  bus clock; registered output.
- sda  out  1  bus data; registered output.

Behaviour:
- Reset values:
  - scl=1, sda=1, grant=0, busy=0, done=0.
  - Phase counter = 0; state = IDLE.
  - RR pointer = NREQ-1, so requester 0 has first priority.
- Reset mid-frame:
  - The next cycle shows idle outputs and the latched code is discarded.
  - A partial frame on the wire is accepted; no abort sequence is generated.
- IDLE (scl=1, sda=1):
  - If any req bit is high, grant the first set bit searching from pointer+1 upward with wrap-around.
  - In that same cycle: pulse grant, latch the 4-bit code, set pointer to the granted index, go to START.
  - If no req bit is high, remain in IDLE.
- Phase timing: each state below lasts exactly DIV cycles, counted by a phase counter that runs 0..DIV-1.
- State sequence after grant, with outputs:
  - START: scl=1, sda=0. This is the sda fall while scl is high.
  - BITn_LO (n=3..0): scl=0, sda=code[n].
  - BITn_HI (n=3..0): scl=1, sda=code[n]. The receiver samples on the scl rise.
  - DUMMY_LO: scl=0, sda=0.
  - DUMMY_HI: scl=1, sda=0. This is the 5th scl rise the receiver needs to re-arm.
  - STOP_LO: scl=0, sda=0.
  - STOP_HI: scl=1, sda=0.
  - GAP: scl=1, sda=1. This is the sda rise while scl is high. done pulses in GAP's last cycle, then the state returns to IDLE.
- Frame length:
  - 14 phases, 14*DIV cycles.
  - If grant is in cycle T, done is in cycle T+14*DIV.
  - The earliest next grant is in cycle T+14*DIV+1.
- Bus legality invariants:
  - sda changes only while scl=0, except the START fall and the GAP rise.
  - scl and sda never change in the same cycle.
- Request handling:
  - req is sampled only in IDLE.
  - Deasserting req after grant has no effect; the frame completes with the latched code.
  - req and data_in changes during a frame are ignored.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority beyond the reset pointer.
- No combinational path exists from req to scl/sda.

Decomposition:
- Shared package frame_bus_pkg holds:
  - FRAME_BITS=4.
  - The phase-state enum: IDLE, START, BIT_LO, BIT_HI, DUMMY_LO, DUMMY_HI, STOP_LO, STOP_HI, GAP.
  - The bit-index counter width.
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Ports: clk, rst, req, advance, grant.
  - Holds the pointer; updates it only on advance.
- The bit index is a 2-bit down-counter in the top level, reused across BIT_LO/BIT_HI.

Test Plan:
All scenarios use NREQ=4, DIV=2, with a behavioural receiver model attached to scl/sda.
1. Single frame: req=0001 after reset, code 4'b1010 → grant=0001 for one cycle; sda sampled at the 5 scl rises = 1,0,1,0,0; done at exactly grant+28 cycles; receiver outhigh=16'h0200.
2. Round-robin: req=1111 held for 5 frames → grants in order 0001, 0010, 0100, 1000, 0001; exactly one grant per frame; grant-to-grant spacing 29 cycles.
3. Request withdrawal: req=0100 with code 4'b0000, dropped in the cycle after grant → full frame still sent; receiver outhigh=16'h8000; no further grant.
4. Reset mid-frame: rst asserted during BIT1_LO → next cycle scl=1, sda=1, busy=0, grant=0; after release with req=1010, grant=0010 (pointer restored to NREQ-1).
5. Invariant monitor across random req/data for 200 frames:
   - No sda edge while scl=1 except one fall per START and one rise per GAP.
   - No cycle where scl and sda toggle together.
   - busy high for exactly 28 cycles per frame.
6. Back-to-back: req=0010 held with code 4'b1111 → next grant in the cycle after done; receiver outhigh=16'h4000 for every frame; the scl high time in IDLE between frames is at least DIV cycles.
